uart_alu_interface: RTL

- Controller that sequences the UART datapath (UART_RX, UART_TX, BR_GENERATOR tick) against an ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents them to the ALU, latches the result, and launches UART_TX to send the result byte back.
- Sits between UART_RX/UART_TX and the ALU in the top-level UART/ALU system.

---
 rtl/uart_alu_interface.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_alu_interface.sv
// Sequences UART_RX bytes (operand A, operand B, opcode) into the ALU and sends the result back via UART_TX.
// Optional inter-byte timeout is built only when UART_ALU_TIMEOUT_EN is defined.
module uart_alu_interface #(
    parameter int DATA_WIDTH    = 8,
    parameter int OP_WIDTH      = 6,
    parameter int TIMEOUT_TICKS = 1600
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_tx_done,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t state_reg;
    logic   timeout_hit;

`ifdef UART_ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    logic [CNT_W-1:0] tick_cnt_reg;
    logic             waiting;

    assign waiting = (state_reg == WAIT_B) || (state_reg == WAIT_OP);
    // A byte arriving on the terminal tick wins over the timeout.
    assign timeout_hit = waiting && i_tick && !i_rx_done &&
                         (tick_cnt_reg == CNT_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            tick_cnt_reg <= '0;
            o_timeout    <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            if (i_rx_done || timeout_hit || !waiting) begin
                tick_cnt_reg <= '0;
            end else if (i_tick) begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg  <= WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            case (state_reg)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_alu_a   <= i_rx_data;
                        state_reg <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_alu_b   <= i_rx_data;
                        state_reg <= WAIT_OP;
                    end else if (timeout_hit) begin
                        state_reg <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_alu_op  <= i_rx_data[OP_WIDTH-1:0];
                        o_busy    <= 1'b1;
                        state_reg <= EXEC;
                    end else if (timeout_hit) begin
                        state_reg <= WAIT_A;
                    end
                end
                EXEC: begin
                    // Operands have been stable for this whole cycle; sample the ALU now.
                    o_overrun  <= i_rx_done;
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state_reg  <= SEND;
                end
                SEND: begin
                    o_overrun <= i_rx_done;
                    if (i_tick) begin
                        o_tx_start <= 1'b0;
                        state_reg  <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    o_overrun <= i_rx_done;
                    if (i_tx_done) begin
                        o_busy    <= 1'b0;
                        state_reg <= WAIT_A;
                    end
                end
                default: begin
                    state_reg <= WAIT_A;
                end
            endcase
        end
    end

endmodule
